// File: rtl/eth_fifo_pkg.sv
// Shared types and helpers for the store-and-forward Ethernet frame FIFO.
package eth_fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 8;
    localparam int PTR_W          = DEF_ADDR_WIDTH + 1;

    typedef enum logic {
        WR_ACCEPT = 1'b0,
        WR_DROP   = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    // Increment v, holding at the all-ones value of a w-bit counter
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] max;
        max = (32'd1 << w) - 32'd1;
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/eth_frame_fifo_ctrl_sdp_ram.sv
// Simple dual-port RAM, one registered read port with sync clear.
module sdp_ram
    import eth_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH + 1
) (
    input  logic                  wr_clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_clk,
    input  logic                  rd_sreset,
    input  logic                  rd_allow,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_sreset) begin
            rd_data <= '0;
        end else if (rd_allow) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_frame_fifo_ctrl.sv
// Store-and-forward frame FIFO: commits whole good frames, drops bad or
// oversized ones, streams committed frames out through a 2-entry skid buffer.
module eth_frame_fifo_ctrl
    import eth_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  sreset_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    input  logic                  s_err,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  drop_pulse,
    output logic [ADDR_WIDTH:0]   fill_level
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int RW = DATA_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PW-1:0] wr_cmt, wr_cur, rd_ptr, fill;
    wr_state_t     wr_state, wr_next;
    rd_state_t     rd_state, rd_next;
    logic          ready_en, full, mid_frame;
    logic          wr_en, commit, drop;
    logic          rd_allow, in_flight, pop, fetch_last, wr_idx, room;
    logic [RW-1:0] rd_data;
    logic [RW-1:0] buf_q [2];
    logic [1:0]    occ;
    logic [2:0]    load;
    logic [CNT_WIDTH-1:0] frame_cnt_nx;

    assign fill       = wr_cur - rd_ptr;
    assign full       = (fill == DEPTH);
    assign mid_frame  = (wr_cur != wr_cmt);
    assign fill_level = fill;

    assign m_valid    = (occ != 2'd0);
    assign m_data     = buf_q[0][DATA_WIDTH-1:0];
    assign m_last     = m_valid & buf_q[0][DATA_WIDTH];
    assign pop        = m_valid & m_ready;
    assign fetch_last = in_flight & rd_data[RW-1];
    assign wr_idx     = (occ == 2'd2) | ((occ == 2'd1) & !pop);
    assign load       = 3'(occ) + 3'(in_flight);
    assign room       = load < (3'd2 + 3'(pop));

    always_comb begin
        wr_next = wr_state;
        s_ready = 1'b0;
        wr_en   = 1'b0;
        commit  = 1'b0;
        drop    = 1'b0;
        unique case (wr_state)
            WR_ACCEPT: begin
                // Overflow mid-frame keeps consuming so the frame can drain
                s_ready = ready_en & (!full | mid_frame);
                if (s_valid & s_ready) begin
                    if (full) begin
                        if (s_last) drop = 1'b1;
                        else wr_next = WR_DROP;
                    end else begin
                        wr_en = 1'b1;
                        if (s_last & !s_err) commit = 1'b1;
                        else if (s_last) drop = 1'b1;
                    end
                end
            end
            WR_DROP: begin
                s_ready = ready_en;
                if (s_valid & s_last) begin
                    drop    = 1'b1;
                    wr_next = WR_ACCEPT;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        frame_cnt_nx = frame_cnt;
        if (commit & !fetch_last) begin
            frame_cnt_nx = frame_cnt + 1'b1;
        end else if (!commit & fetch_last) begin
            frame_cnt_nx = frame_cnt - 1'b1;
        end
    end

    always_comb begin
        rd_next  = rd_state;
        rd_allow = 1'b0;
        unique case (rd_state)
            RD_IDLE: begin
                if (frame_cnt != '0) rd_next = RD_STREAM;
            end
            RD_STREAM: begin
                rd_allow = room & (rd_ptr != wr_cmt);
                if (fetch_last && frame_cnt_nx == '0) rd_next = RD_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sreset_n) begin
            ready_en   <= 1'b0;
            wr_state   <= WR_ACCEPT;
            rd_state   <= RD_IDLE;
            wr_cmt     <= '0;
            wr_cur     <= '0;
            rd_ptr     <= '0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
            in_flight  <= 1'b0;
            occ        <= '0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            ready_en   <= 1'b1;
            wr_state   <= wr_next;
            rd_state   <= rd_next;
            if (wr_en) wr_cur <= wr_cur + 1'b1;
            if (commit) wr_cmt <= wr_cur + 1'b1;
            if (drop) wr_cur <= wr_cmt;
            drop_pulse <= drop;
            if (drop) begin
                drop_cnt <= CNT_WIDTH'(sat_inc(32'(drop_cnt), CNT_WIDTH));
            end
            frame_cnt  <= frame_cnt_nx;
            if (rd_allow) rd_ptr <= rd_ptr + 1'b1;
            in_flight  <= rd_allow;
            if (pop) buf_q[0] <= buf_q[1];
            if (in_flight) buf_q[wr_idx] <= rd_data;
            occ <= occ + {1'b0, in_flight} - {1'b0, pop};
        end
    end

    sdp_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(RW)
    ) u_ram (
        .wr_clk   (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_cur[ADDR_WIDTH-1:0]),
        .wr_data  ({s_last, s_data}),
        .rd_clk   (clk),
        .rd_sreset(~sreset_n),
        .rd_allow (rd_allow),
        .rd_addr  (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_eth_frame_fifo_ctrl.sv
// Directed bench for eth_frame_fifo_ctrl with a 16-word RAM.
module tb_eth_frame_fifo_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          sreset_n, s_valid, s_last, s_err, s_ready;
    logic          m_valid, m_last, m_ready, drop_pulse;
    logic [DW-1:0] s_data, m_data;
    logic [CW-1:0] frame_cnt, drop_cnt;
    logic [AW:0]   fill_level;

    int n_assert = 0;
    int n_fail = 0;
    int wait_sum = 0;
    int stall_err = 0;
    int stall_seen = 0;
    int s0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW:0]   got_q[$];
    logic [DW:0]   exp_q[$];

    eth_frame_fifo_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .sreset_n  (sreset_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_err     (s_err),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .drop_pulse(drop_pulse),
        .fill_level(fill_level)
    );

    always @(posedge clk) begin
        if (!sreset_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && m_data !== prev_data) stall_err <= stall_err + 1;
            if (m_valid && !m_ready) stall_seen <= stall_seen + 1;
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            if (m_valid && m_ready) got_q.push_back({m_last, m_data});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_err   = 1'b0;
        s_data  = '0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic l,
                             input logic e);
        int t = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        s_err   = e;
        #1;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 100) chk("send_timeout", 64'(t), 64'(0));
        wait_sum += t;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int n,
                              input logic e);
        for (int i = 0; i < n; i++) begin
            send_word(base + DW'(i), i == n - 1, e && (i == n - 1));
        end
    endtask

    task automatic exp_frame(input logic [DW-1:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({i == n - 1, base + DW'(i)});
        end
    endtask

    task automatic wait_q(input int n, input int lim);
        int t = 0;
        while (got_q.size() < n && t < lim) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic check_q(input string tag);
        int mism = 0;
        chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
        end
        chk({tag, "_words"}, 64'(mism), 64'(0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
        chk({tag, "_drop_pulse"}, drop_pulse, 0);
        chk({tag, "_fill"}, fill_level, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sreset_n = 1'b0;
        m_ready  = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        chk_reset("rst");
        sreset_n = 1'b1;
        @(negedge clk);
        chk("rst_s_ready_after", s_ready, 1);

        // 1: good 4-word frame, latency and ordering
        got_q.delete();
        send_frame(32'hA0A0_0000, 4, 1'b0);
        idle();
        chk("t1_fcnt_commit", frame_cnt, 1);
        chk("t1_fill_n0", fill_level, 4);
        chk("t1_mvalid_n0", m_valid, 0);
        @(negedge clk);
        chk("t1_mvalid_n1", m_valid, 0);
        @(negedge clk);
        chk("t1_mvalid_n2", m_valid, 0);
        chk("t1_fill_n2", fill_level, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_mvalid", m_valid, 1);
            chk("t1_data", m_data, 32'hA0A0_0000 + 32'(i));
            chk("t1_last", m_last, i == 3);
            chk("t1_fcnt", frame_cnt, (i == 3) ? 0 : 1);
        end
        @(negedge clk);
        chk("t1_mvalid_end", m_valid, 0);

        // 2: errored frame is dropped
        got_q.delete();
        send_frame(32'hB0B0_0000, 3, 1'b1);
        idle();
        chk("t2_drop_pulse", drop_pulse, 1);
        chk("t2_drop_cnt", drop_cnt, 1);
        chk("t2_fill", fill_level, 0);
        @(negedge clk);
        chk("t2_drop_pulse_off", drop_pulse, 0);
        repeat (6) @(negedge clk);
        chk("t2_no_output", 64'(got_q.size()), 0);

        // 3: oversized frame dropped, next frame intact
        got_q.delete();
        wait_sum = 0;
        for (int i = 0; i < 20; i++) begin
            send_word(32'hC0C0_0000 + 32'(i), i == 19, 1'b0);
            if (i == 15) chk("t3_fill_full", fill_level, 16);
        end
        idle();
        chk("t3_ready_stays", 64'(wait_sum), 0);
        chk("t3_drop_pulse", drop_pulse, 1);
        chk("t3_drop_cnt", drop_cnt, 2);
        chk("t3_fill", fill_level, 0);
        send_frame(32'hD0D0_0000, 2, 1'b0);
        idle();
        wait_q(2, 50);
        exp_frame(32'hD0D0_0000, 2);
        check_q("t3_next");

        // 4: two full-depth frames with a stalled sink
        got_q.delete();
        m_ready  = 1'b0;
        wait_sum = 0;
        send_frame(32'hE0E0_0000, 16, 1'b0);
        idle();
        chk("t4_no_wait", 64'(wait_sum), 0);
        chk("t4_full_ready", s_ready, 0);
        chk("t4_full_fill", fill_level, 16);
        @(negedge clk);
        chk("t4_full_ready_n1", s_ready, 0);
        repeat (3) @(negedge clk);
        chk("t4_mvalid", m_valid, 1);
        chk("t4_head", m_data, 32'hE0E0_0000);
        chk("t4_fill_prefetch", fill_level, 14);
        repeat (4) @(negedge clk);
        chk("t4_head_held", m_data, 32'hE0E0_0000);
        chk("t4_fcnt", frame_cnt, 1);
        m_ready = 1'b1;
        wait_q(16, 100);
        exp_frame(32'hE0E0_0000, 16);
        check_q("t4_frame1");
        got_q.delete();
        send_frame(32'hF0F0_0000, 16, 1'b0);
        idle();
        wait_q(16, 100);
        exp_frame(32'hF0F0_0000, 16);
        check_q("t4_frame2");

        // 5: toggling backpressure
        got_q.delete();
        s0 = stall_seen;
        fork
            begin
                send_frame(32'h5050_0000, 8, 1'b0);
                idle();
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    m_ready = ~m_ready;
                end
                m_ready = 1'b1;
            end
        join
        wait_q(8, 50);
        exp_frame(32'h5050_0000, 8);
        check_q("t5_frame");
        chk("t5_stable", 64'(stall_err), 0);
        chk("t5_stalled", stall_seen > s0, 1);

        // 6: reset mid-input, then mid-output
        got_q.delete();
        send_word(32'h6060_0000, 1'b0, 1'b0);
        send_word(32'h6060_0001, 1'b0, 1'b0);
        sreset_n = 1'b0;
        idle();
        @(negedge clk);
        chk_reset("t6_in");
        sreset_n = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        send_frame(32'h7070_0000, 8, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        chk("t6_pre_mvalid", m_valid, 1);
        sreset_n = 1'b0;
        @(negedge clk);
        chk_reset("t6_out");
        sreset_n = 1'b1;
        m_ready  = 1'b1;
        @(negedge clk);
        got_q.delete();
        send_frame(32'h8080_0000, 3, 1'b0);
        idle();
        wait_q(3, 50);
        exp_frame(32'h8080_0000, 3);
        check_q("t6_after");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
